// File: rtl/pdm_cic_decimator.sv
// =============================================================================
// Module   : pdm_cic_decimator
// Purpose  : Avalon-ST CIC decimator, 2-bit signed PDM symbols to 16-bit PCM.
//            Optional build macro CIC_ROUND_EN: round-half-up with saturation.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module pdm_cic_decimator #(
  parameter int ORDER  = 4,
  parameter int DEC    = 32,
  parameter int DIFF_M = 1,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  input  logic [1:0]              in_error,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  output logic [1:0]              out_error,
  input  logic                    out_ready
);

  localparam int c_reg_w = IN_W + ORDER * $clog2(DEC * DIFF_M);
  localparam int c_shift = c_reg_w - OUT_W;
  localparam int c_cnt_w = $clog2(DEC);

  logic [c_cnt_w-1:0]        r_phase;
  logic signed [c_reg_w-1:0] r_integ     [ORDER];
  logic signed [c_reg_w-1:0] w_integ_nxt [ORDER];
  logic signed [c_reg_w-1:0] r_dly       [ORDER][DIFF_M];
  logic signed [c_reg_w-1:0] w_comb      [ORDER+1];
  logic [1:0]                r_err_acc;
  logic signed [OUT_W-1:0]   w_scaled;
  logic                      w_accept;
  logic                      w_fire;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_fire   = w_accept && (r_phase == c_cnt_w'(DEC - 1));

  // Registered cascade: every stage adds the previous stage's old value.
  always_comb begin
    w_integ_nxt[0] = r_integ[0] + c_reg_w'(in_data);
    for (int k = 1; k < ORDER; k++) begin
      w_integ_nxt[k] = r_integ[k] + r_integ[k-1];
    end
  end

  // Comb chain runs on the freshly updated last integrator in the firing cycle.
  always_comb begin
    w_comb[0] = w_integ_nxt[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      w_comb[k+1] = w_comb[k] - r_dly[k][DIFF_M-1];
    end
  end

`ifdef CIC_ROUND_EN
  localparam logic [c_reg_w:0] c_half_lsb = (c_reg_w + 1)'(1) << (c_shift - 1);

  logic [c_reg_w:0] w_rnd_sum;
  logic [OUT_W:0]   w_rnd_q;

  assign w_rnd_sum = {w_comb[ORDER][c_reg_w-1], w_comb[ORDER]} + c_half_lsb;
  assign w_rnd_q   = (OUT_W + 1)'(w_rnd_sum >> c_shift);

  always_comb begin
    w_scaled = w_rnd_q[OUT_W-1:0];
    if (w_rnd_q[OUT_W] != w_rnd_q[OUT_W-1]) begin
      w_scaled = w_rnd_q[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign w_scaled = OUT_W'(w_comb[ORDER] >>> c_shift);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= '0;
        for (int j = 0; j < DIFF_M; j++) begin
          r_dly[k][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= w_integ_nxt[k];
      end
      r_phase <= w_fire ? '0 : r_phase + c_cnt_w'(1);
      if (w_fire) begin
        for (int k = 0; k < ORDER; k++) begin
          r_dly[k][0] <= w_comb[k];
          for (int j = 1; j < DIFF_M; j++) begin
            r_dly[k][j] <= r_dly[k][j-1];
          end
        end
      end
    end
  end

  // A fire can only happen when the held result is absent or being consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_acc <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_error <= 2'b00;
    end else begin
      if (w_accept) begin
        r_err_acc <= w_fire ? 2'b00 : (r_err_acc | in_error);
      end
      if (w_fire) begin
        out_valid <= 1'b1;
        out_data  <= w_scaled;
        out_error <= r_err_acc | in_error;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
// =============================================================================
// Module   : tb_pdm_cic_decimator
// Purpose  : Self-checking bench for pdm_cic_decimator with a reference queue.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pdm_cic_decimator;

  localparam int ORDER  = 4;
  localparam int DEC    = 32;
  localparam int DIFF_M = 1;
  localparam int IN_W   = 2;
  localparam int OUT_W  = 16;
  localparam int c_reg_w = IN_W + ORDER * $clog2(DEC * DIFF_M);
  localparam int c_shift = c_reg_w - OUT_W;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic signed [IN_W-1:0]  in_data = '0;
  logic                    in_valid = 1'b0;
  logic [1:0]              in_error = 2'b00;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic [1:0]              out_error;
  logic                    out_ready = 1'b0;

  always #5 clk = ~clk;

  pdm_cic_decimator #(
    .ORDER (ORDER),
    .DEC   (DEC),
    .DIFF_M(DIFF_M),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_error (in_error),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_error(out_error),
    .out_ready(out_ready)
  );

  typedef struct {
    int         d;
    logic [1:0] e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic signed [c_reg_w-1:0] m_int [ORDER];
  logic signed [c_reg_w-1:0] m_dly [ORDER][DIFF_M];
  int         m_phase;
  logic [1:0] m_err;
  int         m_acc;

  int cyc = 0;
  int n_out, n_err_out, last_out_cyc, stall_data, dc_val;
  bit dc_on, pulse_on, lat_pend, prev_stall;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int scale(input logic signed [c_reg_w-1:0] c);
    longint s;
`ifdef CIC_ROUND_EN
    s = (longint'(c) + (longint'(1) << (c_shift - 1))) >>> c_shift;
    if (s > (longint'(1) << (OUT_W - 1)) - 1) s = (longint'(1) << (OUT_W - 1)) - 1;
    if (s < -(longint'(1) << (OUT_W - 1)))    s = -(longint'(1) << (OUT_W - 1));
`else
    s = longint'(c) >>> c_shift;
`endif
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ORDER; k++) begin
      m_int[k] = '0;
      for (int j = 0; j < DIFF_M; j++) m_dly[k][j] = '0;
    end
    m_phase = 0;
    m_err   = 2'b00;
    m_acc   = 0;
    q.delete();
  endtask

  task automatic model_accept(input logic [1:0] d, input logic [1:0] e);
    logic signed [c_reg_w-1:0] x, c, t;
    logic signed [c_reg_w-1:0] nx [ORDER];
    exp_t ex;
    x = $signed(d);
    nx[0] = m_int[0] + x;
    for (int k = 1; k < ORDER; k++) nx[k] = m_int[k] + m_int[k-1];
    m_int = nx;
    m_err = m_err | e;
    m_acc++;
    if (m_phase == DEC - 1) begin
      m_phase = 0;
      c = m_int[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        t = c - m_dly[k][DIFF_M-1];
        for (int j = DIFF_M - 1; j > 0; j--) m_dly[k][j] = m_dly[k][j-1];
        m_dly[k][0] = c;
        c = t;
      end
      ex.d = scale(c);
      ex.e = m_err;
      q.push_back(ex);
      m_err    = 2'b00;
      lat_pend = 1'b1;
    end else begin
      m_phase++;
    end
  endtask

  task automatic consume();
    exp_t ex;
    if (q.size() == 0) begin
      check("spurious_out", 1, 0);
    end else begin
      ex = q.pop_front();
      check("out_data", int'(out_data), ex.d);
      check("out_error", int'(out_error), int'(ex.e));
    end
    n_out++;
    if (out_error != 2'b00) n_err_out++;
    if (dc_on && n_out >= 6) check("dc_settled", int'(out_data), dc_val);
    if (pulse_on && last_out_cyc >= 0) check("out_period", cyc - last_out_cyc, DEC);
    last_out_cyc = cyc;
  endtask

  task automatic cycle(input logic v, input logic [1:0] d, input logic [1:0] e, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_error  = e;
    out_ready = rdy;
    #1;
    cyc++;
    if (lat_pend) begin
      check("latency", int'(out_valid), 1);
      lat_pend = 1'b0;
    end
    if (prev_stall && out_valid) check("stall_hold", int'(out_data), stall_data);
    prev_stall = out_valid && !out_ready;
    if (prev_stall) begin
      stall_data = int'(out_data);
      check("stall_in_ready", int'(in_ready), 0);
    end
    if (out_valid && out_ready) consume();
    if (in_valid && in_ready) model_accept(d, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_error", int'(out_error), 0);
    model_reset();
    lat_pend     = 1'b0;
    prev_stall   = 1'b0;
    n_out        = 0;
    n_err_out    = 0;
    last_out_cyc = -1;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic drain();
    repeat (40) cycle(1'b0, 2'b00, 2'b00, 1'b1);
    check("drained", q.size(), 0);
  endtask

  initial begin
    logic       v;
    logic [1:0] dd, ee;

    dc_on    = 1'b0;
    pulse_on = 1'b0;
    do_reset();

    // Constant +1: one output every DEC clocks, settling at +16384.
    dc_on    = 1'b1;
    dc_val   = 16384;
    pulse_on = 1'b1;
    repeat (10 * DEC) cycle(1'b1, 2'b01, 2'b00, 1'b1);
    pulse_on = 1'b0;
    dc_on    = 1'b0;

    // Hold a result under backpressure, then reset while it is still valid.
    repeat (45) cycle(1'b1, 2'b01, 2'b00, 1'b1);
    repeat (30) cycle(1'b1, 2'b01, 2'b00, 1'b0);
    do_reset();

    dc_on  = 1'b1;
    dc_val = -16384;
    repeat (10 * DEC) cycle(1'b1, 2'b11, 2'b00, 1'b1);
    drain();

    // Partial window discarded by reset before the -2 run.
    dc_on = 1'b0;
    repeat (13) cycle(1'b1, 2'b01, 2'b00, 1'b1);
    do_reset();
    dc_on  = 1'b1;
    dc_val = -32768;
    repeat (10 * DEC) cycle(1'b1, 2'b10, 2'b00, 1'b1);
    drain();

    do_reset();
    dc_val = 0;
    for (int i = 0; i < 10 * DEC; i++) begin
      dd = (i % 2 == 0) ? 2'b01 : 2'b11;
      cycle(1'b1, dd, 2'b00, 1'b1);
    end
    drain();
    dc_on = 1'b0;

    // Random backpressure with random symbols.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      dd = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
      v  = ($urandom_range(0, 2) != 0);
      cycle(1'b1, dd, 2'b00, v);
    end
    drain();
    check("bp_out_count", n_out, m_acc / DEC);

    // Random input gaps with a single flagged sample in the second window.
    do_reset();
    for (int i = 0; i < 3000 && m_acc < 8 * DEC; i++) begin
      v  = ($urandom_range(0, 2) != 0);
      dd = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
      ee = (v && m_acc == 40) ? 2'b01 : 2'b00;
      cycle(v, dd, ee, 1'b1);
    end
    drain();
    check("gap_accepted", m_acc, 8 * DEC);
    check("gap_out_count", n_out, 8);
    check("err_out_count", n_err_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
